// File: rtl/myprotocol_rx.sv
// Receiver for the three-wire myprotocol interface: deserialises each frame,
// checks even parity, framing and inter-frame gap, and keeps saturating counters.
module myprotocol_rx #(
  parameter int DATA_W  = 8,
  parameter int MIN_GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sig1,
  input  logic              sig2,
  input  logic              sig3,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              err_parity,
  output logic              err_frame,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       err_cnt
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int GW = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W);
  localparam logic [GW-1:0] GAP_MAX  = GW'(MIN_GAP);
  localparam logic [GW-1:0] GAP_ONE  = (MIN_GAP >= 1) ? GW'(1) : GW'(0);

  typedef enum logic [1:0] {IDLE, RX, RESYNC} state_t;

  state_t              state, state_nxt;
  logic [BW-1:0]       bit_cnt, bit_cnt_nxt;
  logic [GW-1:0]       gap_cnt, gap_cnt_nxt;
  logic [DATA_W-1:0]   shreg, shreg_nxt;
  logic                good, perr, ferr;
  logic [DATA_W-1:0]   data_out_nxt;
  logic [15:0]         frame_cnt_nxt, err_cnt_nxt;
  logic                busy_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      gap_cnt    <= GAP_MAX;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      gap_cnt    <= gap_cnt_nxt;
      shreg      <= shreg_nxt;
      data_out   <= data_out_nxt;
      data_valid <= good;
      err_parity <= perr;
      err_frame  <= ferr;
      busy       <= busy_nxt;
      frame_cnt  <= frame_cnt_nxt;
      err_cnt    <= err_cnt_nxt;
    end
  end

  // Exactly one of good/perr/ferr can fire per evaluation, so the pulses stay exclusive.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    shreg_nxt   = shreg;
    good        = 1'b0;
    perr        = 1'b0;
    ferr        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!sig1) begin
          gap_cnt_nxt = (gap_cnt == GAP_MAX) ? gap_cnt : gap_cnt + GW'(1);
        end else if (gap_cnt >= GAP_MAX) begin
          shreg_nxt   = {shreg[DATA_W-2:0], sig2};
          bit_cnt_nxt = BW'(1);
          state_nxt   = RX;
        end else begin
          ferr      = 1'b1;
          state_nxt = RESYNC;
        end
      end
      RX: begin
        if (!sig1) begin
          ferr        = 1'b1;
          bit_cnt_nxt = '0;
          gap_cnt_nxt = GAP_ONE;
          state_nxt   = IDLE;
        end else if (bit_cnt < BIT_LAST) begin
          if (sig3) begin
            ferr        = 1'b1;
            bit_cnt_nxt = '0;
            state_nxt   = RESYNC;
          end else begin
            shreg_nxt   = {shreg[DATA_W-2:0], sig2};
            bit_cnt_nxt = bit_cnt + BW'(1);
          end
        end else if (!sig3) begin
          ferr        = 1'b1;
          bit_cnt_nxt = '0;
          state_nxt   = RESYNC;
        end else begin
          if ((^shreg ^ sig2) == 1'b0) good = 1'b1;
          else                         perr = 1'b1;
          bit_cnt_nxt = '0;
          gap_cnt_nxt = '0;
          state_nxt   = IDLE;
        end
      end
      RESYNC: begin
        if (!sig1) begin
          gap_cnt_nxt = GAP_ONE;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    data_out_nxt  = good ? shreg : data_out;
    frame_cnt_nxt = (good && frame_cnt != 16'hFFFF) ? frame_cnt + 16'd1 : frame_cnt;
    err_cnt_nxt   = ((perr || ferr) && err_cnt != 16'hFFFF) ? err_cnt + 16'd1 : err_cnt;
    busy_nxt      = (state_nxt == RX);
  end

endmodule

// File: tb/tb_myprotocol_rx.sv
// Directed bench for myprotocol_rx: main instance with MIN_GAP=2 plus a
// MIN_GAP=0 instance on the same wires for the back-to-back case.
module tb_myprotocol_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sig1 = 1'b0, sig2 = 1'b0, sig3 = 1'b0;
  logic [7:0]  data_out, data_out0;
  logic        data_valid, err_parity, err_frame, busy;
  logic        data_valid0, err_parity0, err_frame0, busy0;
  logic [15:0] frame_cnt, err_cnt, frame_cnt0, err_cnt0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  myprotocol_rx #(.DATA_W(8), .MIN_GAP(2)) dut (
    .clk(clk), .rst(rst), .sig1(sig1), .sig2(sig2), .sig3(sig3),
    .data_out(data_out), .data_valid(data_valid), .err_parity(err_parity),
    .err_frame(err_frame), .busy(busy), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  myprotocol_rx #(.DATA_W(8), .MIN_GAP(0)) dut0 (
    .clk(clk), .rst(rst), .sig1(sig1), .sig2(sig2), .sig3(sig3),
    .data_out(data_out0), .data_valid(data_valid0), .err_parity(err_parity0),
    .err_frame(err_frame0), .busy(busy0), .frame_cnt(frame_cnt0), .err_cnt(err_cnt0)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after an edge; the task returns just after the
  // edge that sampled them, so registered outputs reflect that sample.
  task automatic apply_stimulus(input logic s1, input logic s2, input logic s3);
    sig1 = s1; sig2 = s2; sig3 = s3;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] word, input logic par, input logic exp_busy);
    for (int i = 7; i >= 0; i--) begin
      apply_stimulus(1'b1, word[i], 1'b0);
      if (i == 7) begin
        check_output("busy_after_cycle0", busy, exp_busy);
        check_output("err_frame_after_cycle0", err_frame, !exp_busy);
      end
    end
    apply_stimulus(1'b1, par, 1'b1);
  endtask

  initial begin
    logic [7:0] w;

    @(posedge clk); #1;
    check_output("rst_data_out", data_out, 8'h00);
    check_output("rst_data_valid", data_valid, 1'b0);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_frame_cnt", frame_cnt, 16'd0);
    check_output("rst_err_cnt", err_cnt, 16'd0);
    rst = 1'b1;
    idle(2);

    send_frame(8'hA5, 1'b0, 1'b1);
    check_output("a5_valid", data_valid, 1'b1);
    check_output("a5_data", data_out, 8'hA5);
    check_output("a5_frame_cnt", frame_cnt, 16'd1);
    check_output("a5_err_cnt", err_cnt, 16'd0);
    check_output("a5_perr", err_parity, 1'b0);
    check_output("a5_busy_fall", busy, 1'b0);
    idle(1);
    check_output("a5_valid_pulse_end", data_valid, 1'b0);
    idle(2);

    send_frame(8'h07, 1'b0, 1'b1);
    check_output("07_perr", err_parity, 1'b1);
    check_output("07_valid", data_valid, 1'b0);
    check_output("07_data_hold", data_out, 8'hA5);
    check_output("07_err_cnt", err_cnt, 16'd1);
    check_output("07_frame_cnt", frame_cnt, 16'd1);
    idle(1);
    check_output("07_perr_pulse_end", err_parity, 1'b0);
    idle(2);

    w = 8'hAA;
    for (int i = 7; i >= 3; i--) apply_stimulus(1'b1, w[i], 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("drop_ferr", err_frame, 1'b1);
    check_output("drop_valid", data_valid, 1'b0);
    check_output("drop_err_cnt", err_cnt, 16'd2);
    check_output("drop_busy", busy, 1'b0);
    idle(1);
    check_output("drop_ferr_pulse_end", err_frame, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1);
    check_output("3c_valid", data_valid, 1'b1);
    check_output("3c_data", data_out, 8'h3C);
    check_output("3c_frame_cnt", frame_cnt, 16'd2);
    idle(3);

    w = 8'hF0;
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(1'b1, (i < 8) ? w[7-i] : 1'b0, (i == 3 || i == 8));
      if (i == 3) begin
        check_output("early_marker_ferr", err_frame, 1'b1);
        check_output("early_marker_err_cnt", err_cnt, 16'd3);
        check_output("early_marker_busy", busy, 1'b0);
      end
    end
    check_output("resync_no_valid", data_valid, 1'b0);
    check_output("resync_no_ferr", err_frame, 1'b0);
    check_output("resync_err_cnt", err_cnt, 16'd3);
    idle(2);
    send_frame(8'h81, 1'b0, 1'b1);
    check_output("81_valid", data_valid, 1'b1);
    check_output("81_data", data_out, 8'h81);
    check_output("81_frame_cnt", frame_cnt, 16'd3);
    idle(3);

    send_frame(8'h11, 1'b0, 1'b1);
    check_output("gap1_first_valid", data_valid, 1'b1);
    idle(1);
    send_frame(8'h22, 1'b0, 1'b0);
    check_output("gap1_second_valid", data_valid, 1'b0);
    check_output("gap1_data", data_out, 8'h11);
    check_output("gap1_frame_cnt", frame_cnt, 16'd4);
    check_output("gap1_err_cnt", err_cnt, 16'd4);
    idle(3);

    send_frame(8'h33, 1'b0, 1'b1);
    check_output("gap2_first_valid", data_valid, 1'b1);
    idle(2);
    send_frame(8'h44, 1'b0, 1'b1);
    check_output("gap2_second_valid", data_valid, 1'b1);
    check_output("gap2_data", data_out, 8'h44);
    check_output("gap2_frame_cnt", frame_cnt, 16'd6);
    check_output("gap2_err_cnt", err_cnt, 16'd4);
    idle(3);

    w = 8'hC3;
    for (int i = 7; i >= 4; i--) apply_stimulus(1'b1, w[i], 1'b0);
    check_output("pre_rst_busy", busy, 1'b1);
    sig1 = 1'b1; sig2 = w[3]; sig3 = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    check_output("async_rst_data_out", data_out, 8'h00);
    check_output("async_rst_busy", busy, 1'b0);
    check_output("async_rst_frame_cnt", frame_cnt, 16'd0);
    check_output("async_rst_err_cnt", err_cnt, 16'd0);
    check_output("async_rst_valid", data_valid, 1'b0);
    check_output("async_rst_ferr", err_frame, 1'b0);
    sig1 = 1'b0; sig2 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    idle(2);
    send_frame(8'h5A, 1'b0, 1'b1);
    check_output("5a_valid", data_valid, 1'b1);
    check_output("5a_data", data_out, 8'h5A);
    check_output("5a_frame_cnt", frame_cnt, 16'd1);
    check_output("5a_err_cnt", err_cnt, 16'd0);
    check_output("gap0_5a_frame_cnt", frame_cnt0, 16'd1);
    idle(3);

    send_frame(8'h11, 1'b0, 1'b1);
    check_output("b2b_gap0_first_valid", data_valid0, 1'b1);
    check_output("b2b_gap0_first_data", data_out0, 8'h11);
    send_frame(8'h22, 1'b0, 1'b0);
    check_output("b2b_gap0_second_valid", data_valid0, 1'b1);
    check_output("b2b_gap0_second_data", data_out0, 8'h22);
    check_output("b2b_gap0_frame_cnt", frame_cnt0, 16'd3);
    check_output("b2b_gap0_err_cnt", err_cnt0, 16'd0);
    check_output("b2b_gap2_data", data_out, 8'h11);
    check_output("b2b_gap2_frame_cnt", frame_cnt, 16'd2);
    check_output("b2b_gap2_err_cnt", err_cnt, 16'd1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/myprotocol_rx.md
# myprotocol_rx

Receiving end of the three-wire `myprotocol` waveform interface. It samples `sig1` (frame enable), `sig2` (serial data) and `sig3` (end-of-frame marker) from the `myprotocol` generator in the same clock domain. It deserialises each frame into a parallel word, checks parity, framing and inter-frame gap, and keeps frame and error counters. It sits directly downstream of the generator and feeds the parallel word to the consumer logic.

## Interface
- `DATA_W`, 8, number of data bits per frame (≥2)
- `MIN_GAP`, 2, minimum `sig1`-low idle cycles required between frames (0 allows back-to-back frames)
- `clk`  in  1  rising-edge clock shared with the generator
- `rst`  in  1  reset, asynchronous, active-low
- `sig1`  in  1  frame enable; high for the whole frame
- `sig2`  in  1  serial data, MSB first, then one even-parity bit
- `sig3`  in  1  end marker; high only on the parity cycle
- `data_out`  out  DATA_W  last good word; holds its value between frames
- `data_valid`  out  1  one-cycle pulse when `data_out` is updated
- `err_parity`  out  1  one-cycle pulse on parity failure
- `err_frame`  out  1  one-cycle pulse on length, marker or gap violation
- `busy`  out  1  high while state is RX
- `frame_cnt`  out  16  good frames received; saturates at 16'hFFFF
- `err_cnt`  out  16  parity plus frame errors; saturates at 16'hFFFF

## Operation
- Inputs are synchronous to `clk`. No synchronisers. All inputs are sampled on the rising edge.
- A frame is `sig1` high for exactly DATA_W+1 consecutive cycles:
  - Cycles 0..DATA_W-1 carry data bits DATA_W-1..0 on `sig2`.
  - Cycle DATA_W carries the parity bit on `sig2`, with `sig3`=1.
- Parity is even: XOR of all data bits and the parity bit must be 0.
- The state machine has three states: IDLE, RX, RESYNC. Counters are `bit_cnt` (0..DATA_W) and `gap_cnt` (saturates at MIN_GAP).
- IDLE:
  - While `sig1`=0, `gap_cnt` increments.
  - On `sig1`=1 with `gap_cnt`≥MIN_GAP: shift in `sig2`, set `bit_cnt`=1, go to RX.
  - On `sig1`=1 with `gap_cnt`<MIN_GAP: pulse `err_frame`, go to RESYNC.
- RX with `bit_cnt`<DATA_W:
  - `sig1`=0: pulse `err_frame`, go to IDLE with `gap_cnt`=1.
  - `sig3`=1 (early marker): pulse `err_frame`, go to RESYNC.
  - Otherwise: shift in `sig2`, increment `bit_cnt`.
- RX with `bit_cnt`=DATA_W (parity cycle):
  - `sig1`=0: pulse `err_frame`, go to IDLE with `gap_cnt`=1.
  - `sig1`=1, `sig3`=0: pulse `err_frame`, go to RESYNC.
  - Parity good: load `data_out`, pulse `data_valid`, increment `frame_cnt`.
  - Parity bad: pulse `err_parity`; `data_out` is unchanged.
  - In both parity cases, go to IDLE with `gap_cnt`=0.
- RESYNC: ignore `sig2`/`sig3`. On `sig1`=0, go to IDLE with `gap_cnt`=1.
- Every `err_*` pulse increments `err_cnt`.
- Each terminated frame produces exactly one of `data_valid`, `err_parity`, `err_frame`. Two of them are never high in the same cycle.
- When `sig1` stays high after a good frame, the first post-frame cycle is evaluated in IDLE as a gap violation if MIN_GAP>0. If MIN_GAP=0, it is the start of the next frame.

## Timing
- Reset (`rst`=0), applied asynchronously:
  - State IDLE, `gap_cnt`=MIN_GAP (first frame after reset is accepted).
  - `bit_cnt`=0 and the shift register cleared.
  - `data_out`=0, `data_valid`/`err_parity`/`err_frame`/`busy`=0, `frame_cnt`=`err_cnt`=0.
- Reset mid-frame discards the partial word and reports no error.
- All outputs are registered.
- `data_valid`/`err_parity` are high for exactly the one cycle after the parity cycle.
- `err_frame` is high for the one cycle after the violating sample.
- `busy` rises the cycle after frame cycle 0 is sampled and falls the cycle after the frame terminates.
- Throughput: one word per DATA_W+1+MIN_GAP cycles.

## Test plan
(DATA_W=8, MIN_GAP=2 unless stated)
- Release reset, send 0xA5 with parity 0 → one cycle after the parity cycle: `data_out`=0xA5, `data_valid` high 1 cycle, `frame_cnt`=1, `err_cnt`=0.
- Send 0x07 with parity 0 → `err_parity` 1-cycle pulse, `data_out` stays 0xA5, `err_cnt`=1, `frame_cnt` unchanged.
- Drop `sig1` after 5 data bits → `err_frame` pulse, no `data_valid`. After 1 more idle cycle, send 0x3C with parity 0 → accepted, `data_out`=0x3C.
- Raise `sig3` on data bit 3 → `err_frame` pulse; the rest of the frame is ignored. After `sig1` low for ≥2 cycles, 0x81 is accepted.
- Two good frames separated by 1 idle cycle → second gives `err_frame`. Repeat with 2 idle cycles → both accepted, `frame_cnt`+2. With MIN_GAP=0, back-to-back frames (no idle cycle) → both accepted.
- Assert `rst` during data bit 4 → all outputs 0 immediately (between clock edges). After release, 0x5A is received correctly with `frame_cnt`=1.
